// File: rtl/ro_meas_scheduler_pkg.sv
// Shared definitions for the ring-oscillator measurement scheduler:
// state encoding, default geometry and the counter-reset polarity.
package ro_sched_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CH_W_DEF  = 2;
  localparam int WIN_W_DEF = 8;
  localparam int SET_W_DEF = 4;

  // The RO counter clears while its reset input is low
  localparam logic ROCNT_RST_ACTIVE = 1'b0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEL  = 3'd1;
  localparam logic [2:0] ST_RST  = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_EN   = 3'd4;
  localparam logic [2:0] ST_CAP  = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_SEL  = ST_SEL,
    S_RST  = ST_RST,
    S_GAP  = ST_GAP,
    S_EN   = ST_EN,
    S_CAP  = ST_CAP,
    S_DONE = ST_DONE
  } sched_state_e;

endpackage

// File: rtl/ro_meas_scheduler_if.sv
// Configuration inputs and RO mux/counter/readout controls of the scheduler.
// master = scheduler side, slave = SPI front end / RO datapath side.
interface ro_meas_scheduler_if
  import ro_sched_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CH_W  = CH_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int SET_W = SET_W_DEF
);
  logic [N_CH-1:0]  Ch_Mask;
  logic [WIN_W-1:0] Win_Cnt;
  logic [SET_W-1:0] Settle_Cnt;
  logic [CH_W-1:0]  Ro_Sel;
  logic             ROCNT_Rst;
  logic             ENOUT;
  logic             Cap_Stb;
  logic [CH_W-1:0]  Cap_Ch;
  logic             Busy;
  logic             Done;

  modport master (
    input  Ch_Mask, Win_Cnt, Settle_Cnt,
    output Ro_Sel, ROCNT_Rst, ENOUT, Cap_Stb, Cap_Ch, Busy, Done
  );

  modport slave (
    output Ch_Mask, Win_Cnt, Settle_Cnt,
    input  Ro_Sel, ROCNT_Rst, ENOUT, Cap_Stb, Cap_Ch, Busy, Done
  );
endinterface

// File: rtl/ro_meas_scheduler_prio_find.sv
// Finds the lowest set mask bit strictly above i_cur; i_cur = -1 picks the
// lowest set bit overall.
module ro_ch_prio_find #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0]        i_mask,
  input  logic signed [CH_W:0]   i_cur,
  output logic [CH_W-1:0]        o_idx,
  output logic                   o_vld
);

  // Descending scan so the lowest qualifying bit is the last one written
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i > int'(i_cur))) begin
        o_idx = CH_W'(i);
        o_vld = 1'b1;
      end else begin
        o_vld = o_vld;
      end
    end
  end

endmodule

// File: rtl/ro_meas_scheduler.sv
// Walks the channel mask and, per enabled RO, runs select/settle, counter
// reset, recovery gap, count window and capture. Updates on SPI_Clk falling edges.
module ro_meas_scheduler
  import ro_sched_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CH_W  = CH_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int SET_W = SET_W_DEF
) (
  input  logic                   SPI_Clk,
  input  logic                   SPICNT_RST,
  ro_meas_scheduler_if.master    bus
);

  sched_state_e       r_state, w_state_nxt;
  logic [CH_W-1:0]    r_ch, w_ch_nxt;
  logic [WIN_W-1:0]   r_cnt, w_cnt_nxt;
  logic [N_CH-1:0]    r_mask, w_mask_nxt;
  logic [WIN_W-1:0]   r_win, w_win_nxt;
  logic [SET_W-1:0]   r_set, w_set_nxt;

  logic [CH_W-1:0]    r_ro_sel;
  logic               r_rocnt_rst;
  logic               r_enout;
  logic               r_cap_stb;
  logic [CH_W-1:0]    r_cap_ch;
  logic               r_busy;
  logic               r_done;
  logic [CH_W-1:0]    w_cap_ch_nxt;

  logic [N_CH-1:0]      w_pf_mask;
  logic signed [CH_W:0] w_pf_cur;
  logic [CH_W-1:0]      w_pf_idx;
  logic                 w_pf_vld;
  logic [SET_W-1:0]     w_set_src;
  logic [WIN_W-1:0]     w_set_len;

  // In IDLE the live config drives the first pick; afterwards the latched copy
  always_comb begin
    if (r_state == S_IDLE) begin
      w_pf_mask = bus.Ch_Mask;
      w_pf_cur  = '1;
      w_set_src = bus.Settle_Cnt;
    end else begin
      w_pf_mask = r_mask;
      w_pf_cur  = {1'b0, r_ch};
      w_set_src = r_set;
    end
    if (w_set_src == '0) begin
      w_set_len = WIN_W'(1);
    end else begin
      w_set_len = WIN_W'(w_set_src);
    end
  end

  ro_ch_prio_find #(.N_CH(N_CH), .CH_W(CH_W)) u_prio (
    .i_mask (w_pf_mask),
    .i_cur  (w_pf_cur),
    .o_idx  (w_pf_idx),
    .o_vld  (w_pf_vld)
  );

  // Next-state, channel, down-counter and config-latch logic
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    w_win_nxt   = r_win;
    w_set_nxt   = r_set;
    case (r_state)
      S_IDLE: begin
        w_mask_nxt = bus.Ch_Mask;
        w_win_nxt  = bus.Win_Cnt;
        w_set_nxt  = bus.Settle_Cnt;
        if (w_pf_vld) begin
          w_state_nxt = S_SEL;
          w_ch_nxt    = w_pf_idx;
          w_cnt_nxt   = w_set_len;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_SEL: begin
        if (r_cnt <= WIN_W'(1)) begin
          w_state_nxt = S_RST;
        end else begin
          w_cnt_nxt = r_cnt - WIN_W'(1);
        end
      end
      S_RST: w_state_nxt = S_GAP;
      S_GAP: begin
        if (r_win == '0) begin
          w_state_nxt = S_CAP;
        end else begin
          w_state_nxt = S_EN;
          w_cnt_nxt   = r_win;
        end
      end
      S_EN: begin
        if (r_cnt <= WIN_W'(1)) begin
          w_state_nxt = S_CAP;
        end else begin
          w_cnt_nxt = r_cnt - WIN_W'(1);
        end
      end
      S_CAP: begin
        if (w_pf_vld) begin
          w_state_nxt = S_SEL;
          w_ch_nxt    = w_pf_idx;
          w_cnt_nxt   = w_set_len;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt == S_CAP) begin
      w_cap_ch_nxt = w_ch_nxt;
    end else begin
      w_cap_ch_nxt = r_cap_ch;
    end
  end

  // State and registered outputs, decoded from the next state
  always_ff @(negedge SPI_Clk or negedge SPICNT_RST) begin
    if (!SPICNT_RST) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_win       <= '0;
      r_set       <= '0;
      r_ro_sel    <= '0;
      r_rocnt_rst <= ~ROCNT_RST_ACTIVE;
      r_enout     <= 1'b0;
      r_cap_stb   <= 1'b0;
      r_cap_ch    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ch        <= w_ch_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mask      <= w_mask_nxt;
      r_win       <= w_win_nxt;
      r_set       <= w_set_nxt;
      r_ro_sel    <= w_ch_nxt;
      r_rocnt_rst <= (w_state_nxt == S_RST) ? ROCNT_RST_ACTIVE : ~ROCNT_RST_ACTIVE;
      r_enout     <= (w_state_nxt == S_EN);
      r_cap_stb   <= (w_state_nxt == S_CAP);
      r_cap_ch    <= w_cap_ch_nxt;
      r_busy      <= (w_state_nxt == S_SEL) || (w_state_nxt == S_RST) ||
                     (w_state_nxt == S_GAP) || (w_state_nxt == S_EN)  ||
                     (w_state_nxt == S_CAP);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.Ro_Sel    = r_ro_sel;
  assign bus.ROCNT_Rst = r_rocnt_rst;
  assign bus.ENOUT     = r_enout;
  assign bus.Cap_Stb   = r_cap_stb;
  assign bus.Cap_Ch    = r_cap_ch;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;

endmodule

// File: tb/tb_ro_meas_scheduler.sv
// Directed bench for ro_meas_scheduler: edge-by-edge schedule checks with
// hand-derived expected outputs, counted through immediate assertions.
module tb_ro_meas_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ro_meas_scheduler_if bus();

  ro_meas_scheduler dut (
    .SPI_Clk    (clk),
    .SPICNT_RST (rst_n),
    .bus        (bus)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed output vector {Ro_Sel, ROCNT_Rst, ENOUT, Cap_Stb, Cap_Ch, Busy, Done}
  task automatic chk_out(input string tag, input logic [1:0] rs, input logic rr,
                         input logic en, input logic cs, input logic [1:0] cc,
                         input logic b, input logic d);
    chk(tag, {23'd0, bus.Ro_Sel, bus.ROCNT_Rst, bus.ENOUT, bus.Cap_Stb,
              bus.Cap_Ch, bus.Busy, bus.Done},
             {23'd0, rs, rr, en, cs, cc, b, d});
  endtask

  // Advance one falling edge and sample shortly after it
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int p;
    int ch;
    int en_cnt [4];
    int caps [$];
    int done_edge;

    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    bus.Ch_Mask = 4'b0000;
    bus.Win_Cnt = 8'd0;
    bus.Settle_Cnt = 4'd0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("reset_async", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    repeat (2) step();
    chk_out("reset_held", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // Test 1: mask 0101, settle 2, window 5; config changes mid-run must be ignored
    bus.Ch_Mask = 4'b0101;
    bus.Settle_Cnt = 4'd2;
    bus.Win_Cnt = 8'd5;
    rst_n = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      step();
      if (e == 3) begin
        bus.Ch_Mask = 4'b1111;
        bus.Win_Cnt = 8'd1;
        bus.Settle_Cnt = 4'd7;
      end
      if (e > 20) begin
        chk_out($sformatf("t1_e%0d", e), 2'd2, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1);
      end else begin
        ch = (e <= 10) ? 0 : 2;
        p  = (e <= 10) ? e : e - 10;
        chk_out($sformatf("t1_e%0d", e), ch[1:0], (p != 3), (p >= 5 && p <= 9),
                (p == 10), (e >= 20) ? 2'd2 : 2'd0, 1'b1, 1'b0);
      end
    end

    // Test 2: empty mask goes straight to DONE with no counter activity
    enter_reset();
    bus.Ch_Mask = 4'b0000;
    bus.Settle_Cnt = 4'd2;
    bus.Win_Cnt = 8'd5;
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk_out($sformatf("t2_e%0d", e), 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    end

    // Test 3: mask 1000, settle 0 behaves as 1, window 0 skips ENOUT
    enter_reset();
    bus.Ch_Mask = 4'b1000;
    bus.Settle_Cnt = 4'd0;
    bus.Win_Cnt = 8'd0;
    rst_n = 1'b1;
    step(); chk_out("t3_e1_sel", 2'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step(); chk_out("t3_e2_rst", 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step(); chk_out("t3_e3_gap", 2'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step(); chk_out("t3_e4_cap", 2'd3, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
    step(); chk_out("t3_e5_done", 2'd3, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
    step(); chk_out("t3_e6_done", 2'd3, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1);

    // Test 4: all channels, window 255, settle 3 -> 261 edges per channel
    enter_reset();
    bus.Ch_Mask = 4'b1111;
    bus.Settle_Cnt = 4'd3;
    bus.Win_Cnt = 8'd255;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) en_cnt[i] = 0;
    done_edge = 0;
    for (int e = 1; e <= 1200 && done_edge == 0; e++) begin
      step();
      if (bus.ENOUT) en_cnt[bus.Ro_Sel]++;
      if (bus.Cap_Stb) caps.push_back(int'(bus.Cap_Ch));
      if (bus.Done) done_edge = e;
    end
    chk("t4_done_edge", done_edge, 1045);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_enout_ch%0d", i), en_cnt[i], 255);
    chk("t4_cap_count", caps.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_cap_order%0d", i), (i < caps.size()) ? caps[i] : 99, i);

    // Test 5: reset during channel 1 window, then restart from lowest bit
    enter_reset();
    bus.Ch_Mask = 4'b0011;
    bus.Settle_Cnt = 4'd1;
    bus.Win_Cnt = 8'd4;
    rst_n = 1'b1;
    repeat (13) step();
    chk_out("t5_mid_en", 2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("t5_async_drop", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    repeat (3) step();
    chk_out("t5_no_cap", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(); chk_out("t5_restart_sel", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step(); chk_out("t5_restart_rst", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
